// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter: geometry, the
// architectural zero register and the writeback requester indices.
package rf_pkg;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_MDU  = 2'd2
    } req_id_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating priority starting at r_ptr, one-hot grant plus
// encoded index; the pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    localparam logic [IW:0]   LN   = (IW+1)'(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    logic [IW-1:0]  r_ptr;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic           w_hit;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    // Rotating right by the pointer puts the highest-priority requester at bit 0.
    assign w_dbl = {i_req, i_req} >> r_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_hit = 1'b1;
                w_off = IW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= LN)
            w_sum = w_sum - LN;
        o_idx = w_sum[IW-1:0];
        o_gnt = (w_hit && !i_rst) ? (N'(1) << o_idx) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= '0;
        else if (|o_gnt)
            r_ptr <= (o_idx == LAST) ? '0 : o_idx + IW'(1);
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback sources and keeps the
// pending-write scoreboard used by issue for RAW/WAW stalls.
module regfile_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]    REQ_READY,
    output logic               RF_WE,
    output logic [AW-1:0]      RF_AWR,
    output logic [DW-1:0]      RF_DIN,
    output logic [1:0]         GRANT_ID,
    input  logic               RSV_VALID,
    input  logic [AW-1:0]      RSV_ADDR,
    output logic [31:0]        BUSY
);
    import rf_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_acc;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [NREG-1:0] w_busy_nxt;

    logic            r_we;
    logic [AW-1:0]   r_awr;
    logic [DW-1:0]   r_din;
    logic [1:0]      r_gid;
    logic [NREG-1:0] r_busy;

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_clk (CLK),
        .i_rst (RST),
        .i_req (REQ_VALID),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_acc = |w_gnt;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_addr = REQ_ADDR[i*AW +: AW];
                w_data = REQ_DATA[i*DW +: DW];
            end
        end
    end

    // A $zero write still completes its handshake; only the file write is suppressed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_we  <= 1'b0;
            r_awr <= '0;
            r_din <= '0;
            r_gid <= '0;
        end else begin
            r_we <= w_acc && (w_addr != ZERO_REG);
            if (w_acc) begin
                r_awr <= w_addr;
                r_din <= w_data;
                r_gid <= 2'(w_idx);
            end
        end
    end

    // Clear on retirement, then set, so a same-edge reservation wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we)
            w_busy_nxt[r_awr] = 1'b0;
        if (RSV_VALID && (RSV_ADDR != ZERO_REG))
            w_busy_nxt[RSV_ADDR] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign REQ_READY = w_gnt;
    assign RF_WE     = r_we;
    assign RF_AWR    = r_awr;
    assign RF_DIN    = r_din;
    assign GRANT_ID  = r_gid;
    assign BUSY      = r_busy;
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file between NREQ writeback sources: ALU result, load data, mult/div unit.
- Round-robin grant with a valid/ready handshake per requester.
- Registers the winning write onto the register-file WE/address/data lines.
- Keeps a pending-write scoreboard (BUSY) that the issue stage uses to stall on RAW/WAW hazards.

Parameters:
- NREQ, 3, number of writeback requesters.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  NREQ  per-requester write request.
- REQ_ADDR  input  NREQ*AW  destination register; requester i occupies bits [i*AW +: AW].
- REQ_DATA  input  NREQ*DW  write data; requester i occupies bits [i*DW +: DW].
- REQ_READY  output  NREQ  one-hot or zero; a transfer occurs when VALID and READY are both high.
- RF_WE  output  1  register-file write enable (registered).
- RF_AWR  output  AW  register-file write address (registered).
- RF_DIN  output  DW  register-file write data (registered).
- GRANT_ID  output  2  index of the last accepted requester (registered).
- RSV_VALID  input  1  issue stage reserves a destination register.
- RSV_ADDR  input  AW  register being reserved.
- BUSY  output  32  scoreboard; bit a high means a write to register a is outstanding.

Behaviour:
- Reset (RST high at posedge):
  - RF_WE=0, RF_AWR=0, RF_DIN=0, GRANT_ID=0, BUSY=0, round-robin pointer=0.
  - A write accepted in the same cycle is dropped; RF_WE is 0 afterward.
- Grant (combinational):
  - Search for the first asserted REQ_VALID starting at the pointer index, wrapping modulo NREQ.
  - REQ_READY is high only for that requester. All READY are 0 when no VALID is high, and during RST.
- Requester rules: VALID, ADDR and DATA must be held stable until READY is seen. Dropping VALID before READY is allowed (the request is withdrawn).
- Pointer:
  - On acceptance from requester i, pointer becomes (i+1) mod NREQ.
  - With no acceptance, the pointer holds.
  - Starvation bound: at most NREQ-1 cycles between VALID rising and READY.
- Write path, one-cycle latency:
  - Acceptance at edge N drives RF_WE=1, RF_AWR=addr, RF_DIN=data, GRANT_ID=i during cycle N..N+1.
  - The register file captures the write at edge N+1.
  - With no acceptance at edge N, RF_WE=0 and RF_AWR/RF_DIN hold their previous values.
- $zero suppression: an accepted request with addr==0 completes the handshake (READY high, pointer advances, GRANT_ID updates) but RF_WE stays 0.
- Throughput: one write per cycle; back-to-back grants to different requesters are allowed.
- Scoreboard:
  - Set: at posedge, if RSV_VALID and RSV_ADDR!=0, BUSY[RSV_ADDR] is set.
  - Clear: at posedge, if RF_WE, BUSY[RF_AWR] is cleared. Clearing happens when the write retires into the file, not on acceptance, so BUSY=0 guarantees the file already holds the data.
  - Set and clear of the same address at one edge: set wins.
  - BUSY[0] is constant 0.
  - Reserving an already-busy register leaves it busy. The issue stage must not do this (WAW stall), so this case is a protocol error and is not tracked.
  - A write to a non-busy register is legal and has no scoreboard effect.

Decomposition:
- Shared package rf_pkg holds:
  - constants NREQ=3, AW=5, DW=32, NREG=32, ZERO_REG=0;
  - requester index names REQ_ALU=0, REQ_LOAD=1, REQ_MDU=2.
- Natural sub-module rr_arbiter (parameter N): pointer register plus rotate-priority grant, producing a one-hot grant and an encoded index.
- Write register and scoreboard stay in the top level.

Test Plan:
- Reset then idle:
  - Stimulus: RST=1 for 2 cycles, then all VALID=0.
  - Required: RF_WE=0, BUSY=0, REQ_READY=000 for 10 cycles.
- Single write:
  - Stimulus: REQ_VALID=001, ADDR0=5, DATA0=32'hDEADBEEF.
  - Required: READY=001 the same cycle. The next cycle shows RF_WE=1, RF_AWR=5, RF_DIN=DEADBEEF, GRANT_ID=0, then RF_WE=0.
- Round-robin:
  - Stimulus: all three VALID held high with addresses 1/2/3.
  - Required: grants in order 0, 1, 2 on consecutive cycles; RF_AWR sequence 1, 2, 3.
- Fairness:
  - Stimulus: requester 0 VALID continuously with new data each accept; requester 2 raises VALID at cycle 3.
  - Required: requester 2 is granted within 2 cycles, then requester 0 resumes.
- $zero write:
  - Stimulus: REQ_VALID=010, ADDR1=0, DATA1=7.
  - Required: READY=010, RF_WE stays 0, GRANT_ID=1; BUSY[0] is never set, including after RSV_ADDR=0 is presented.
- Scoreboard:
  - Stimulus: RSV to reg 9 at edge 0.
    - Required: BUSY[9]=1 after that edge.
  - Stimulus: the write to 9 is accepted at edge 4.
    - Required: BUSY[9] clears at edge 5 together with RF_WE retiring.
  - Stimulus: RSV 9 again at edge 5.
    - Required: BUSY[9] stays 1 (set wins).
  - Stimulus: RST asserted in the accept cycle.
    - Required: no RF_WE and BUSY=0.
